mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised N-channel, W-bit registered channel selector for the lab top level. It replaces the fixed 4:1 single-bit combinational mux. In manual mode, an external select picks the channel. In auto mode, the block rotates through the channels at a programmable tick rate. A one-hot LED vector shows the active channel, so the selector can drive board LEDs directly.

## Interface
- `N_CH`, default 4: number of input channels, ≥2.
- `W`, default 1: width of each channel in bits.
- `PERIOD`, default 5000000: clock cycles per auto-scan step, ≥1.
- `SELW`, default `$clog2(N_CH)`: select width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mode`  in  1  0 = manual select, 1 = auto scan.
- `hold`  in  1  1 = freeze the scan prescaler and the scan position in auto mode; no effect in manual mode.
- `s`  in  SELW  manual channel select.
- `a`  in  N_CH*W  packed channel data; channel k = `a[k*W +: W]`.
- `y`  out  W  registered selected channel data.
- `cur_sel`  out  SELW  channel currently presented on `y`.
- `valid`  out  1  1 when `cur_sel` addresses an existing channel.
- `led`  out  N_CH  one-hot of `cur_sel`; all zero when `valid`=0.

## Operation
- Registers:
  - prescaler `cnt` (range 0..PERIOD-1)
  - select register `sel`
  - output registers `y`, `valid`, `led`
  - `mode_q`, the previous-cycle `mode`, used for edge detection
- Reset (rst=0 sampled at a rising edge): `cnt`=0, `sel`=0, `y`=0, `valid`=1, `led`=1 (bit 0 set), `mode_q`=0. Reset overrides every other input.
- Tick: `tick` = (`cnt`==PERIOD-1) & ~`hold` & `mode`.
  - Each cycle with `mode`=1 and `hold`=0, `cnt` increments and wraps from PERIOD-1 to 0.
  - With `hold`=1, `cnt` is held.
  - With `mode`=0, `cnt` is forced to 0.
  - PERIOD=1 gives a tick every unheld cycle.
- Manual mode (`mode`=0): `sel_next` = `s`.
- Auto mode (`mode`=1):
  - On `tick`, `sel_next` = (`sel`==N_CH-1) ? 0 : `sel`+1.
  - Otherwise `sel_next` = `sel`.
  - If `sel` ≥ N_CH on entry to auto mode, `sel_next` = 0 on the first tick.
- Mode entry (`mode`=1, `mode_q`=0): scanning starts from the current `sel`, and `cnt` restarts at 0. The first step therefore occurs exactly PERIOD unheld cycles after entry.
- Output path: `sel` <= `sel_next`. `y`, `valid` and `led` are computed from `sel_next` in the same edge, so `y`, `cur_sel` and `led` are always mutually consistent.
  - `cur_sel` = `sel`.
- Out of range: when N_CH is not a power of two and `sel_next` ≥ N_CH, `y`=0, `valid`=0 and `led`=0. No wrap or truncation is applied to `s`.
- Arithmetic: `sel` increments are SELW-bit with an explicit compare at N_CH-1. `cnt` width is `$clog2(PERIOD+1)`.

## Timing
- Latency from `a` or `s` change to `y`: 1 clock. `y` reflects inputs sampled at the previous rising edge.
- Auto step: `cur_sel` and `led` change on the edge where `cnt`==PERIOD-1 is sampled. Step interval is PERIOD cycles with `hold`=0; each `hold` cycle extends the interval by one cycle.
- `hold` asserted in the tick cycle suppresses that tick. The tick occurs on the first following unheld cycle.
- Auto to manual switch: `sel` takes `s` at the next edge. Any pending prescaler progress is discarded.
- Reset mid-scan: the next edge after `rst`=0 forces the reset values regardless of `mode`, `hold` or `cnt`.
- No combinational path from inputs to outputs.

## Structure
- Package `mux_scan_pkg`: `mode_e` enum (`MODE_MANUAL`=0, `MODE_AUTO`=1) and the function `onehot(sel, n)` used for `led`.
- Sub-module `tick_gen`: contains the prescaler.
  - Parameter: `PERIOD`.
  - Inputs: `clk`, `rst`, `en` (= `mode`), `hold`.
  - Output: `tick`.
  - Also used by future LED and display blocks.
- Top-level `mux_scan` contains the select register, the mode-edge register, the output registers and the slice mux.

## Test plan
- Reset, manual select (N_CH=4, W=1): rst=0 for 2 cycles → `y`=0, `cur_sel`=0, `led`=4'b0001, `valid`=1. Then `mode`=0, `a`=4'b1010, s=1 → next cycle `y`=1, `led`=4'b0010. Then s=2 → `y`=0, `led`=4'b0100.
- Wide channels (N_CH=4, W=8): `a`={8'hD4,8'hC3,8'hB2,8'hA1}, s=3 → `y`=8'hD4 one cycle after `s` is applied.
- Auto scan with wrap (PERIOD=4): `mode`=1 from `sel`=2 → `cur_sel` sequence 2,3,0,1,2. Each value is held exactly 4 cycles, and `led` tracks `cur_sel` one-hot.
- Hold (PERIOD=4): assert `hold` for 3 cycles mid-interval → that step arrives 7 cycles after the previous one. `hold` asserted on the tick cycle → no step that cycle.
- Non-power-of-two (N_CH=3, W=4): manual s=3 → `y`=0, `valid`=0, `led`=3'b000. Switch to auto with PERIOD=2 → first tick gives `cur_sel`=0, `valid`=1.
- Reset mid-scan: auto mode with `cnt`=2 and `sel`=1; pulse rst=0 for 1 cycle → `cur_sel`=0, `led`=0001. The first step after release requires `mode`=1 and PERIOD full cycles.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan shared types and helpers.
// Mode encoding and the one-hot LED decoder.
package mux_scan_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Widest LED vector the decoder can produce.
    localparam int MAX_CH = 32;

    function automatic logic [MAX_CH-1:0] onehot(
        input int sel,
        input int n
    );
        logic [MAX_CH-1:0] v;
        v = '0;
        if (sel >= 0 && sel < n && sel < MAX_CH) begin
            v[sel[4:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Channel selector bus: control, channel data
// and the registered selection outputs.
interface mux_scan_if #(
    parameter int N_CH = 4,
    parameter int W    = 1,
    parameter int SELW = $clog2(N_CH)
);
    logic              mode;
    logic              hold;
    logic [SELW-1:0]   s;
    logic [N_CH*W-1:0] a;
    logic [W-1:0]      y;
    logic [SELW-1:0]   cur_sel;
    logic              valid;
    logic [N_CH-1:0]   led;

    modport master (
        output mode, hold, s, a,
        input  y, cur_sel, valid, led
    );

    modport slave (
        input  mode, hold, s, a,
        output y, cur_sel, valid, led
    );

endinterface

// File: rtl/mux_scan_tick_gen.sv
// Scan prescaler: one tick every PERIOD
// enabled, unheld cycles.
module tick_gen #(
    parameter int PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hold,
    output logic tick
);
    localparam int CW = $clog2(PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    // Count while enabled and unheld; disabled forces a restart at 0.
    always_comb begin
        at_last = (cnt_q == LAST);
        tick    = at_last & ~hold & en;
        cnt_d   = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel selector with manual select
// and timed auto-scan, plus one-hot LED output.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W      = 1,
    parameter int PERIOD = 5000000,
    parameter int SELW   = $clog2(N_CH)
) (
    input logic       clk,
    input logic       rst,
    mux_scan_if.slave bus
);
    localparam logic [SELW-1:0] LAST_SEL = SELW'(N_CH - 1);

    mode_e           mode_q;
    mode_e           mode_d;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_d;
    logic            oor_q;
    logic            oor_d;
    logic [W-1:0]    y_q;
    logic [W-1:0]    y_d;
    logic            valid_q;
    logic            valid_d;
    logic [N_CH-1:0] led_q;
    logic [N_CH-1:0] led_d;

    logic tick;
    logic entry;
    logic sel_oor;
    logic oor_pend;
    logic wrap;

    tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.mode),
        .hold (bus.hold),
        .tick (tick)
    );

    // Next select: manual follows s, auto steps on tick;
    // an out-of-range position held at scan entry restarts at 0.
    always_comb begin
        mode_d   = mode_e'(bus.mode);
        entry    = (mode_d == MODE_AUTO) && (mode_q == MODE_MANUAL);
        sel_oor  = int'(sel_q) >= N_CH;
        oor_pend = entry ? sel_oor : oor_q;
        wrap     = (sel_q == LAST_SEL) | oor_pend;
        sel_d    = sel_q;
        oor_d    = 1'b0;
        unique case (mode_d)
            MODE_MANUAL: begin
                sel_d = bus.s;
            end
            MODE_AUTO: begin
                if (tick) begin
                    sel_d = wrap ? '0 : sel_q + SELW'(1);
                end else begin
                    oor_d = oor_pend;
                end
            end
            default: begin
                sel_d = sel_q;
            end
        endcase
    end

    // Output data, valid and LEDs all derive from the next select.
    always_comb begin
        y_d     = '0;
        valid_d = int'(sel_d) < N_CH;
        led_d   = N_CH'(onehot(int'(sel_d), N_CH));
        for (int k = 0; k < N_CH; k++) begin
            if (sel_d == SELW'(k)) begin
                y_d = bus.a[k*W +: W];
            end
        end
    end

    // Select, mode-edge and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= MODE_MANUAL;
            sel_q   <= '0;
            oor_q   <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b1;
            led_q   <= N_CH'(1);
        end else begin
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            oor_q   <= oor_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            led_q   <= led_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.cur_sel = sel_q;
    assign bus.valid   = valid_q;
    assign bus.led     = led_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three configurations driven
// with directed and random stimulus against a model.
module tb_mux_scan;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_scan_if #(.N_CH(4), .W(8)) bus0 ();
    mux_scan_if #(.N_CH(3), .W(4)) bus1 ();
    mux_scan_if #(.N_CH(4), .W(1)) bus2 ();

    mux_scan #(.N_CH(4), .W(8), .PERIOD(4)) u0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    mux_scan #(.N_CH(3), .W(4), .PERIOD(2)) u1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    mux_scan #(.N_CH(4), .W(1), .PERIOD(1)) u2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    logic        md[3];
    logic        hd[3];
    logic [1:0]  sd[3];
    logic [31:0] ad[3];

    assign bus0.mode = md[0];
    assign bus0.hold = hd[0];
    assign bus0.s    = sd[0];
    assign bus0.a    = ad[0];
    assign bus1.mode = md[1];
    assign bus1.hold = hd[1];
    assign bus1.s    = sd[1];
    assign bus1.a    = ad[1][11:0];
    assign bus2.mode = md[2];
    assign bus2.hold = hd[2];
    assign bus2.s    = sd[2];
    assign bus2.a    = ad[2][3:0];

    int NN[3];
    int WW[3];
    int PP[3];

    int          msel[3];
    int          mprog[3];
    logic [31:0] ey[3];
    logic [31:0] eled[3];
    logic        ev[3];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behaviour in terms of unheld auto cycles since the last step.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mprog[i] = 0;
                msel[i]  = 0;
                ey[i]    = 0;
                ev[i]    = 1'b1;
                eled[i]  = 1;
            end else begin
                if (!md[i]) begin
                    mprog[i] = 0;
                    msel[i]  = int'(sd[i]);
                end else if (!hd[i]) begin
                    mprog[i]++;
                    if (mprog[i] == PP[i]) begin
                        mprog[i] = 0;
                        msel[i] = (msel[i] >= NN[i] - 1) ? 0 : msel[i] + 1;
                    end
                end
                if (msel[i] < NN[i]) begin
                    ev[i]   = 1'b1;
                    eled[i] = 32'd1 << msel[i];
                    ey[i]   = (ad[i] >> (msel[i] * WW[i]))
                            & ((32'd1 << WW[i]) - 1);
                end else begin
                    ev[i]   = 1'b0;
                    eled[i] = 0;
                    ey[i]   = 0;
                end
            end
        end
    endtask

    task automatic chk_out(
        input int          i,
        input logic [31:0] y,
        input logic [31:0] cs,
        input logic [31:0] v,
        input logic [31:0] led
    );
        check($sformatf("y%0d", i), y, ey[i]);
        check($sformatf("cur_sel%0d", i), cs, 32'(msel[i]));
        check($sformatf("valid%0d", i), v, 32'(ev[i]));
        check($sformatf("led%0d", i), led, eled[i]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_out(0, 32'(bus0.y), 32'(bus0.cur_sel), 32'(bus0.valid), 32'(bus0.led));
        chk_out(1, 32'(bus1.y), 32'(bus1.cur_sel), 32'(bus1.valid), 32'(bus1.led));
        chk_out(2, 32'(bus2.y), 32'(bus2.cur_sel), 32'(bus2.valid), 32'(bus2.led));
    endtask

    initial begin
        NN = '{4, 3, 4};
        WW = '{8, 4, 1};
        PP = '{4, 2, 1};
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            md[i] = 1'b0;
            hd[i] = 1'b0;
            sd[i] = 2'd0;
            ad[i] = 32'h0;
        end

        // Reset state
        cyc();
        cyc();
        check("rst_y", 32'(bus2.y), 32'h0);
        check("rst_sel", 32'(bus2.cur_sel), 32'h0);
        check("rst_led", 32'(bus2.led), 32'h1);
        check("rst_valid", 32'(bus2.valid), 32'h1);

        // Manual select, single-bit channels
        rst = 1'b1;
        ad[2] = 32'b1010;
        sd[2] = 2'd1;
        cyc();
        check("man_y1", 32'(bus2.y), 32'h1);
        check("man_led1", 32'(bus2.led), 32'b0010);
        sd[2] = 2'd2;
        cyc();
        check("man_y2", 32'(bus2.y), 32'h0);
        check("man_led2", 32'(bus2.led), 32'b0100);

        // Wide channels
        ad[0] = 32'hD4C3B2A1;
        sd[0] = 2'd3;
        cyc();
        check("wide_y3", 32'(bus0.y), 32'hD4);

        // Out-of-range manual select on the 3-channel unit
        ad[1] = 32'h0000_0ABC;
        sd[1] = 2'd3;
        cyc();
        check("oor_valid", 32'(bus1.valid), 32'h0);
        check("oor_led", 32'(bus1.led), 32'h0);
        check("oor_y", 32'(bus1.y), 32'h0);

        // Auto entry from out of range: first tick lands on 0
        md[1] = 1'b1;
        sd[0] = 2'd2;
        cyc();
        cyc();
        check("oor_auto_sel", 32'(bus1.cur_sel), 32'h0);
        check("oor_auto_valid", 32'(bus1.valid), 32'h1);

        // Auto scan with wrap from 2: 3,0,1,2 every 4 cycles
        md[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k % 4 == 3) begin
                check("scan_hold_val", 32'(bus0.cur_sel), 32'((k / 4 + 2) % 4));
            end
            if (k % 4 == 0) begin
                check("scan_step", 32'(bus0.cur_sel), 32'((k / 4 + 2) % 4));
            end
        end

        // Three held cycles stretch the interval to 7
        cyc();
        hd[0] = 1'b1;
        cyc();
        cyc();
        cyc();
        hd[0] = 1'b0;
        cyc();
        cyc();
        check("hold_pre", 32'(bus0.cur_sel), 32'h2);
        cyc();
        check("hold_step", 32'(bus0.cur_sel), 32'h3);

        // Hold in the tick cycle suppresses the step
        cyc();
        cyc();
        cyc();
        hd[0] = 1'b1;
        cyc();
        check("hold_tick", 32'(bus0.cur_sel), 32'h3);
        hd[0] = 1'b0;
        cyc();
        check("hold_release", 32'(bus0.cur_sel), 32'h0);

        // Reset mid-scan with sel=1, cnt=2
        for (int k = 0; k < 6; k++) begin
            cyc();
        end
        rst = 1'b0;
        cyc();
        check("midrst_sel", 32'(bus0.cur_sel), 32'h0);
        check("midrst_led", 32'(bus0.led), 32'h1);
        rst = 1'b1;
        cyc();
        cyc();
        cyc();
        check("midrst_wait", 32'(bus0.cur_sel), 32'h0);
        cyc();
        check("midrst_step", 32'(bus0.cur_sel), 32'h1);

        // Random traffic on all three units
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    md[i] = ~md[i];
                end
                hd[i] = ($urandom_range(0, 3) == 0);
                sd[i] = 2'($urandom_range(0, 3));
                ad[i] = $urandom;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
